// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      XFER = 2'd2
   } state_t;

   // Index of the set bit in a one-hot requester vector (0 when empty).
   function automatic logic oh_to_idx(input logic [NREQ-1:0] oh);
      logic idx;
      idx = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = 1'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick among eligible requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; a requester simply stays unpicked while ineligible.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] eligible,
   input  logic            last_grant,
   output logic [NREQ-1:0] grant,
   output logic            grant_valid
);

   // A lone eligible requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant = eligible;
      if (eligible == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

   assign grant_valid = |eligible;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-address memory between two requesters (req/ack handshake).
// Latency: Req sampled at grant edge -> Ack pulse three cycles later; one transfer per 3 cycles.
// Backpressure: requester holds Req until its Ack; losers simply wait in IDLE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 2
)(
   input  logic               Clock,
   input  logic               ResetN,
   input  logic [NREQ-1:0]    Req,
   input  logic [NREQ-1:0]    Wr,
   input  logic [NREQ*M-1:0]  Addr,
   input  logic [NREQ*N-1:0]  WData,
   output logic [NREQ-1:0]    Ack,
   output logic [N-1:0]       RData,
   output logic               Busy,
   output logic [M-1:0]       Select,
   output logic               RW,
   inout  wire  [N-1:0]       DataBus
);

   state_t          state;
   logic            owner;
   logic            wr_q;
   logic [N-1:0]    wdata_q;
   logic            last_grant;

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic            grant_valid;
   logic            grant_idx;
   logic [M-1:0]    grant_addr;
   logic [N-1:0]    grant_wdata;

   // Masking by Ack stops a requester that drops Req in its Ack cycle from being re-granted.
   assign eligible = Req & ~Ack;

   rr_arbiter2 u_rr (
      .eligible    (eligible),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign grant_idx   = oh_to_idx(grant);
   assign grant_addr  = grant_idx ? Addr[2*M-1:M]  : Addr[M-1:0];
   assign grant_wdata = grant_idx ? WData[2*N-1:N] : WData[N-1:0];

   // Only a write in XFER drives the bus; RW is high exactly then, so the memory is silent.
   assign DataBus = (state == XFER && wr_q) ? wdata_q : 'z;

   // Grant, address phase, transfer phase; all outputs registered, reset abandons any transfer.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state      <= IDLE;
         owner      <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         last_grant <= 1'b1;
         Select     <= '0;
         RW         <= 1'b0;
         Ack        <= '0;
         RData      <= '0;
         Busy       <= 1'b0;
      end else begin
         Ack <= '0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner      <= grant_idx;
                  wr_q       <= Wr[grant_idx];
                  wdata_q    <= grant_wdata;
                  Select     <= grant_addr;
                  last_grant <= grant_idx;
                  Busy       <= 1'b1;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               // Memory registers Select on this edge; write strobe rises for the next cycle.
               RW    <= wr_q;
               state <= XFER;
            end
            XFER: begin
               if (!wr_q) RData <= DataBus;
               RW         <= 1'b0;
               Ack[owner] <= 1'b1;
               Busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               RW    <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, directed table, corner sequences, random agents.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

   logic        Clock;
   logic        ResetN;
   logic [1:0]  Req;
   logic [1:0]  Wr;
   logic [3:0]  Addr;
   logic [15:0] WData;
   logic [1:0]  Ack;
   logic [7:0]  RData;
   logic        Busy;
   logic [1:0]  Select;
   logic        RW;
   wire  [7:0]  DataBus;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(.N(8), .M(2)) dut (
      .Clock   (Clock),
      .ResetN  (ResetN),
      .Req     (Req),
      .Wr      (Wr),
      .Addr    (Addr),
      .WData   (WData),
      .Ack     (Ack),
      .RData   (RData),
      .Busy    (Busy),
      .Select  (Select),
      .RW      (RW),
      .DataBus (DataBus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Behavioural memory: registered select, writes when RW=1, drives the bus when RW=0.
   logic [7:0] mem [0:3];
   logic [1:0] mem_sel_q;
   logic       mem_clr;

   always @(posedge Clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         mem_sel_q <= '0;
      end else begin
         if (RW) mem[mem_sel_q] <= DataBus;
         mem_sel_q <= Select;
      end
   end

   assign DataBus = RW ? 8'bz : mem[mem_sel_q];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: a single server that accepts one request per 3 edges,
   // picks round-robin, and refuses the just-acked requester on the edge ending its Ack.
   int         ec = 0;
   int         g_edge = 0;
   int         next_free = 0;
   bit         pend = 0;
   bit         have_prev = 0;
   bit         last = 1;
   bit         g_own = 0;
   bit         g_wr = 0;
   logic [1:0] g_addr = '0;
   logic [7:0] g_data = '0;
   logic [1:0] exp_sel = '0;
   logic [7:0] exp_rdata = '0;
   logic [1:0] el;
   logic [1:0] exp_ack;
   logic [7:0] ref_mem [0:3];

   initial begin : model_chk
      for (int i = 0; i < 4; i++) ref_mem[i] = '0;
      forever begin
         @(posedge Clock);
         ec++;
         if (!ResetN) begin
            pend = 0; have_prev = 0; last = 1; next_free = 0;
            exp_sel = '0; exp_rdata = '0;
         end else begin
            if (pend && ec == g_edge + 2) begin
               if (g_wr) ref_mem[g_addr] = g_data;
               else      exp_rdata = ref_mem[g_addr];
            end
            if (ec >= next_free) begin
               el = Req;
               if (have_prev && ec == next_free) el[last] = 1'b0;
               if (el != 2'b00) begin
                  g_own     = (el == 2'b11) ? ~last : el[1];
                  g_wr      = Wr[g_own];
                  g_addr    = Addr[g_own*2 +: 2];
                  g_data    = WData[g_own*8 +: 8];
                  g_edge    = ec;
                  next_free = ec + 3;
                  last      = g_own;
                  have_prev = 1;
                  pend      = 1;
                  exp_sel   = g_addr;
               end
            end
         end
         #1;
         exp_ack = 2'b00;
         if (pend && ec == g_edge + 2) exp_ack[g_own] = 1'b1;
         chk("ack", Ack, exp_ack);
         chk("busy", Busy, pend && (ec - g_edge) < 2);
         chk("rw", RW, pend && g_wr && ec == g_edge + 1);
         chk("select", Select, exp_sel);
         chk("rdata", RData, exp_rdata);
         if (pend && g_wr && ec == g_edge + 1) chk("bus_wdata", DataBus, g_data);
         if (pend && g_wr && ec == g_edge + 2) chk("mem_cell", mem[g_addr], g_data);
      end
   end

   // Single request from one requester; returns edges to Ack (bounded) and RData then.
   task automatic issue(input int rq, input bit wr, input logic [1:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
      @(negedge Clock);
      Req[rq] = 1'b1; Wr[rq] = wr; Addr[rq*2 +: 2] = a; WData[rq*8 +: 8] = d;
      lat = 0;
      while (lat < 20) begin
         @(posedge Clock); #2;
         lat++;
         if (Ack[rq]) break;
      end
      rd = RData;
      @(negedge Clock);
      Req[rq] = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge Clock); ResetN = 1'b0;
      @(negedge Clock); ResetN = 1'b1;
   endtask

   typedef struct {
      int         rq;
      bit         wr;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];
   int   lat, cyc, t0, t1;
   logic [7:0] rd;
   int   order [$];
   int   when  [$];

   initial begin
      ResetN = 1'b0; Req = '0; Wr = '0; Addr = '0; WData = '0; mem_clr = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_ack", Ack, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_rw", RW, 0);
      chk("rst_select", Select, 0);
      chk("rst_rdata", RData, 0);
      @(negedge Clock); ResetN = 1'b1; mem_clr = 1'b0;

      // Directed single transfers; cell 0 is left untouched for the reset test.
      vecs[0] = '{0, 1'b1, 2'd2, 8'hA5, 8'h00};
      vecs[1] = '{1, 1'b0, 2'd2, 8'h00, 8'hA5};
      vecs[2] = '{1, 1'b1, 2'd1, 8'h5A, 8'h00};
      vecs[3] = '{0, 1'b0, 2'd1, 8'hEE, 8'h5A};
      vecs[4] = '{0, 1'b1, 2'd3, 8'hFF, 8'h00};
      vecs[5] = '{1, 1'b0, 2'd3, 8'h00, 8'hFF};
      vecs[6] = '{1, 1'b0, 2'd0, 8'h00, 8'h00};
      vecs[7] = '{0, 1'b0, 2'd2, 8'h00, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].rq, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd);
         chk("vec_latency", lat, 3);
         if (vecs[i].wr) chk("vec_mem", mem[vecs[i].addr], vecs[i].wdata);
         else            chk("vec_rdata", rd, vecs[i].exp_rdata);
      end

      // Simultaneous writes after reset: requester 0 first, then 1, three cycles apart.
      pulse_reset();
      @(negedge Clock);
      Req = 2'b11; Wr = 2'b11; Addr = {2'd3, 2'd1}; WData = {8'h33, 8'h11};
      cyc = 0; t0 = -1; t1 = -1;
      while (cyc < 20 && (t0 < 0 || t1 < 0)) begin
         @(posedge Clock); #2;
         cyc++;
         if (Ack[0]) t0 = cyc;
         if (Ack[1]) t1 = cyc;
         @(negedge Clock);
         Req = Req & ~Ack;
      end
      Req = 2'b00;
      chk("both_first_ack", t0, 3);
      chk("both_second_ack", t1, 6);
      chk("both_cell1", mem[1], 8'h11);
      chk("both_cell3", mem[3], 8'h33);

      // Continuous requests from both sides: strict alternation, one transfer per 3 cycles.
      @(negedge Clock);
      Req = 2'b11; Wr = 2'b00; Addr = {2'd3, 2'd1};
      cyc = 0;
      while (cyc < 40 && order.size() < 6) begin
         @(posedge Clock); #2;
         cyc++;
         if (Ack[0]) begin order.push_back(0); when.push_back(cyc); end
         if (Ack[1]) begin order.push_back(1); when.push_back(cyc); end
      end
      @(negedge Clock);
      Req = 2'b00;
      chk("cont_count", order.size(), 6);
      for (int k = 0; k < order.size(); k++) begin
         chk("cont_order", order[k], k % 2);
         if (k > 0) chk("cont_gap", when[k] - when[k-1], 3);
      end

      // Reset during the XFER of a write to cell 0: abandoned, no Ack, no write.
      @(negedge Clock);
      Req[0] = 1'b1; Wr[0] = 1'b1; Addr[1:0] = 2'd0; WData[7:0] = 8'h3C;
      @(posedge Clock); #2;
      @(posedge Clock); #2;
      chk("xfer_rw", RW, 1);
      @(negedge Clock);
      ResetN = 1'b0; Req = 2'b00;
      #1;
      chk("arst_ack", Ack, 0);
      chk("arst_busy", Busy, 0);
      chk("arst_rw", RW, 0);
      chk("arst_rdata", RData, 0);
      repeat (3) begin
         @(posedge Clock); #2;
         chk("arst_no_ack", Ack, 0);
      end
      chk("arst_cell0", mem[0], 8'h00);
      @(negedge Clock); ResetN = 1'b1;
      issue(1, 1'b0, 2'd0, 8'h00, lat, rd);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_rdata", rd, 8'h00);

      // Req dropped in the Ack cycle with the other side idle: no second grant.
      issue(1, 1'b1, 2'd1, 8'h77, lat, rd);
      chk("drop_latency", lat, 3);
      repeat (4) begin
         @(posedge Clock); #2;
         chk("drop_no_ack", Ack, 0);
         chk("drop_idle", Busy, 0);
      end

      // Random agents: hold Req until Ack, sometimes reissue back-to-back, sometimes
      // withdraw early, and scramble Wr/Addr/WData while waiting.
      for (int c = 0; c < 400; c++) begin
         @(negedge Clock);
         for (int i = 0; i < 2; i++) begin
            if (Req[i]) begin
               if (Ack[i]) begin
                  if ($urandom_range(1) == 0) Req[i] = 1'b0;
                  else begin
                     Wr[i] = 1'($urandom_range(1));
                     Addr[i*2 +: 2] = 2'($urandom_range(3));
                     WData[i*8 +: 8] = 8'($urandom);
                  end
               end else if ($urandom_range(15) == 0) begin
                  Req[i] = 1'b0;
               end else if ($urandom_range(3) == 0) begin
                  Wr[i] = 1'($urandom_range(1));
                  Addr[i*2 +: 2] = 2'($urandom_range(3));
                  WData[i*8 +: 8] = 8'($urandom);
               end
            end else if ($urandom_range(2) == 0) begin
               Req[i] = 1'b1;
               Wr[i] = 1'($urandom_range(1));
               Addr[i*2 +: 2] = 2'($urandom_range(3));
               WData[i*8 +: 8] = 8'($urandom);
            end
         end
      end
      @(negedge Clock);
      Req = 2'b00;
      repeat (6) @(posedge Clock);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
